// File: rtl/mau_ahb_lsq_if.sv
// rtl/mau_ahb_lsq_if.sv - Request, AHB-Lite and writeback signal bundle for mau_ahb_lsq
interface mau_ahb_lsq_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [4:0]        req_rd;

  logic [31:0]       haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [6:0]        hprot;
  logic [1:0]        htrans;
  logic              hmastlock;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  logic              load_en;
  logic [4:0]        load_rd;
  logic [DATA_W-1:0] load_data;
  logic              err_valid;
  logic [31:0]       err_addr;
  logic              err_misalign;
  logic              busy;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_size, req_sext, req_rd,
    input  hready, hresp, hrdata,
    output req_ready,
    output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
    output load_en, load_rd, load_data, err_valid, err_addr, err_misalign, busy
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_size, req_sext, req_rd,
    output hready, hresp, hrdata,
    input  req_ready,
    input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
    input  load_en, load_rd, load_data, err_valid, err_addr, err_misalign, busy
  );
endinterface

// File: rtl/mau_ahb_lsq.sv
// rtl/mau_ahb_lsq.sv - Load/store request queue issuing pipelined AHB-Lite single transfers
module mau_ahb_lsq #(
  parameter int         DATA_W    = 32,
  parameter int         DEPTH     = 4,
  parameter logic [6:0] HPROT_VAL = 7'b0000011
) (
  input logic           hclk,
  input logic           hrst,
  mau_ahb_lsq_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OB = $clog2(DATA_W / 8);

  typedef struct packed {
    logic              wr;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              sext;
    logic [4:0]        rd;
  } entry_t;

  entry_t            q [DEPTH];
  entry_t            head;
  entry_t            in_entry;
  logic [PW:0]       wptr, rptr;
  logic              empty, full;
  logic              misalign, accept, enq, issue, pop;
  logic              err_first, err_last, ld_done;

  logic              dp_valid;
  logic              dp_wr;
  logic [31:0]       dp_addr;
  logic [1:0]        dp_size;
  logic              dp_sext;
  logic [4:0]        dp_rd;
  logic [DATA_W-1:0] dp_wdata;

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] ld_ext;
  logic              ld_sign;

  function automatic logic [DATA_W-1:0] repl(input logic [DATA_W-1:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    repl = {(DATA_W/8){d[7:0]}};
      2'd1:    repl = {(DATA_W/16){d[15:0]}};
      2'd2:    repl = {(DATA_W/32){d[31:0]}};
      default: repl = d;
    endcase
  endfunction

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign head  = q[rptr[PW-1:0]];

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      default: misalign = (DATA_W != 64) || (|bus.req_addr[2:0]);
    endcase
  end

  assign accept    = bus.req_valid && !full;
  assign enq       = accept && !misalign;
  assign err_first = dp_valid && bus.hresp && !bus.hready;
  assign err_last  = dp_valid && bus.hresp && bus.hready;
  // Both error cycles hold the address phase off; the head stays queued for re-issue.
  assign issue     = !empty && !(dp_valid && bus.hresp);
  assign pop       = issue && bus.hready;
  assign ld_done   = dp_valid && !dp_wr && bus.hready && !bus.hresp;

  assign in_entry = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata,
                      size: bus.req_size, sext: bus.req_sext, rd: bus.req_rd};

  always_ff @(posedge hclk) begin
    if (enq) q[wptr[PW-1:0]] <= in_entry;
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Data-phase register advances only when the current data phase (if any) ends.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      dp_valid <= 1'b0;
      dp_wr    <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
      dp_sext  <= 1'b0;
      dp_rd    <= '0;
      dp_wdata <= '0;
    end else if (bus.hready) begin
      dp_valid <= pop;
      if (pop) begin
        dp_wr    <= head.wr;
        dp_addr  <= head.addr;
        dp_size  <= head.size;
        dp_sext  <= head.sext;
        dp_rd    <= head.rd;
        dp_wdata <= repl(head.wdata, head.size);
      end
    end
  end

  assign lane = bus.hrdata >> {dp_addr[OB-1:0], 3'b000};

  always_comb begin
    ld_sign = 1'b0;
    case (dp_size)
      2'd0:    ld_sign = dp_sext & lane[7];
      2'd1:    ld_sign = dp_sext & lane[15];
      2'd2:    ld_sign = dp_sext & lane[31];
      default: ld_sign = dp_sext & lane[DATA_W-1];
    endcase
    ld_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_ext[i] = (i < (8 << dp_size)) ? lane[i] : ld_sign;
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      bus.load_en      <= 1'b0;
      bus.load_rd      <= '0;
      bus.load_data    <= '0;
      bus.err_valid    <= 1'b0;
      bus.err_addr     <= '0;
      bus.err_misalign <= 1'b0;
    end else begin
      bus.load_en <= ld_done;
      if (ld_done) begin
        bus.load_rd   <= dp_rd;
        bus.load_data <= ld_ext;
      end
      // A bus error outranks a same-cycle misaligned reject for the single error slot.
      bus.err_valid <= err_last || (accept && misalign);
      if (err_last) begin
        bus.err_addr     <= dp_addr;
        bus.err_misalign <= 1'b0;
      end else if (accept && misalign) begin
        bus.err_addr     <= bus.req_addr;
        bus.err_misalign <= 1'b1;
      end
    end
  end

  assign bus.req_ready = !full;
  assign bus.htrans    = issue ? 2'b10 : 2'b00;
  assign bus.haddr     = empty ? 32'h0 : head.addr;
  assign bus.hwrite    = !empty && head.wr;
  assign bus.hsize     = empty ? 3'd0 : {1'b0, head.size};
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = HPROT_VAL;
  assign bus.hmastlock = 1'b0;
  assign bus.hwdata    = dp_wdata;
  assign bus.busy      = !empty || dp_valid;

  logic unused_err_first;
  assign unused_err_first = err_first;
endmodule
